// File: rtl/bcd_counter_chain.sv
// bcd_counter_chain: cascaded BCD counter, runtime limit, wrap/saturate.
// Define BCD_CHAIN_DOWN_EN to enable down-counting selected by dir.
module bcd_counter_chain #(
  parameter int DIGITS = 4,
  parameter logic [4*DIGITS-1:0] RST_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  dir,
  input  logic                  mode,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic [4*DIGITS-1:0]   limit,
  input  logic [4*DIGITS-1:0]   match_val,
  output logic [4*DIGITS-1:0]   Qdata,
  output logic                  tc,
  output logic                  ovf,
  output logic [DIGITS-1:0]     blink
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0]    q;
  logic [W-1:0]    q_nxt;
  logic [W-1:0]    ld_q;
  logic [W-1:0]    inc_q;
  logic [W-1:0]    dec_q;
  logic [DIGITS:0] cy;
  logic            tc_r;
  logic            tc_nxt;
  logic            ovf_r;
  logic            ovf_nxt;
  logic            up_term;
  logic            dn_term;
  logic            go_down;

  // Load value with any non-BCD digit forced to zero
  always_comb begin
    ld_q = load_val;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] > 4'd9) begin
        ld_q[4*i +: 4] = 4'd0;
      end
    end
  end

  // Increment with carry resolved across every digit in one cycle
  always_comb begin
    inc_q = q;
    cy    = '0;
    cy[0] = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (cy[i]) begin
        inc_q[4*i +: 4] = (q[4*i +: 4] == 4'd9) ?
                          4'd0 : q[4*i +: 4] + 4'd1;
      end
      cy[i+1] = cy[i] & (q[4*i +: 4] == 4'd9);
    end
  end

  // Terminal for up: live limit match, or all-9s above limit
  assign up_term = (q == limit) | cy[DIGITS];

`ifdef BCD_CHAIN_DOWN_EN
  logic [DIGITS:0] bw;

  // Decrement with borrow; a full borrow chain means zero
  always_comb begin
    dec_q = q;
    bw    = '0;
    bw[0] = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (bw[i]) begin
        dec_q[4*i +: 4] = (q[4*i +: 4] == 4'd0) ?
                          4'd9 : q[4*i +: 4] - 4'd1;
      end
      bw[i+1] = bw[i] & (q[4*i +: 4] == 4'd0);
    end
  end

  assign go_down = dir;
  assign dn_term = bw[DIGITS];
`else
  logic unused_dir;

  assign unused_dir = dir;
  assign dec_q      = q;
  assign go_down    = 1'b0;
  assign dn_term    = 1'b0;
`endif

  // Next state: load beats step, step beats hold
  always_comb begin
    q_nxt   = q;
    tc_nxt  = 1'b0;
    ovf_nxt = ovf_r;
    if (load) begin
      q_nxt   = ld_q;
      ovf_nxt = 1'b0;
    end else if (ena) begin
      if (go_down) begin
        if (dn_term) begin
          tc_nxt = 1'b1;
          if (!mode) begin
            q_nxt   = limit;
            ovf_nxt = 1'b1;
          end
        end else begin
          q_nxt = dec_q;
        end
      end else begin
        if (up_term) begin
          tc_nxt = 1'b1;
          if (!mode) begin
            q_nxt   = '0;
            ovf_nxt = 1'b1;
          end
        end else begin
          q_nxt = inc_q;
        end
      end
    end
  end

  // State registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q     <= RST_VAL;
      tc_r  <= 1'b0;
      ovf_r <= 1'b0;
    end else begin
      q     <= q_nxt;
      tc_r  <= tc_nxt;
      ovf_r <= ovf_nxt;
    end
  end

  // Per-digit equality against match_val for the blink LEDs
  always_comb begin
    blink = '0;
    for (int i = 0; i < DIGITS; i++) begin
      blink[i] = (q[4*i +: 4] == match_val[4*i +: 4]);
    end
  end

  assign Qdata = q;
  assign tc    = tc_r;
  assign ovf   = ovf_r;

endmodule

// File: tb/tb_bcd_counter_chain.sv
// tb_bcd_counter_chain: directed vectors plus an integer-arithmetic model.
// Checks Qdata/tc/ovf/blink every cycle and pins key literal values.
module tb_bcd_counter_chain;

  localparam int D   = 4;
  localparam int W   = 4 * D;
  localparam int MAX = 9999;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         ena = 1'b0;
  logic         dir = 1'b0;
  logic         mode = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] limit = 16'h9675;
  logic [W-1:0] match_val = '0;
  logic [W-1:0] Qdata;
  logic         tc;
  logic         ovf;
  logic [D-1:0] blink;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  logic [W-1:0] mq;
  logic         mtc;
  logic         movf;

  bcd_counter_chain #(.DIGITS(D)) dut (
    .clk(clk), .rst(rst), .ena(ena), .dir(dir),
    .mode(mode), .load(load), .load_val(load_val),
    .limit(limit), .match_val(match_val),
    .Qdata(Qdata), .tc(tc), .ovf(ovf), .blink(blink)
  );

  always #5 clk = ~clk;

  function automatic int b2i(logic [W-1:0] b);
    int v = 0;
    for (int i = D - 1; i >= 0; i--) v = v * 10 + int'(b[4*i +: 4]);
    return v;
  endfunction

  function automatic logic [W-1:0] i2b(int v);
    logic [W-1:0] r = '0;
    int t = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] clean(logic [W-1:0] v);
    logic [W-1:0] r = v;
    for (int i = 0; i < D; i++)
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd0;
    return r;
  endfunction

  function automatic logic [D-1:0] mblink(logic [W-1:0] a,
                                          logic [W-1:0] m);
    logic [D-1:0] r = '0;
    for (int i = 0; i < D; i++) r[i] = (a[4*i +: 4] == m[4*i +: 4]);
    return r;
  endfunction

  function automatic bit down_on();
`ifdef BCD_CHAIN_DOWN_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_step(input logic [W-1:0] q, input logic ov,
                            output logic [W-1:0] nq,
                            output logic ntc, output logic nov);
    nq = q; ntc = 1'b0; nov = ov;
    if (load) begin
      nq = clean(load_val); nov = 1'b0;
    end else if (ena) begin
      if (down_on() && dir) begin
        if (b2i(q) == 0) begin
          ntc = 1'b1;
          if (!mode) begin nq = limit; nov = 1'b1; end
        end else begin
          nq = i2b(b2i(q) - 1);
        end
      end else begin
        if (q == limit || b2i(q) == MAX) begin
          ntc = 1'b1;
          if (!mode) begin nq = '0; nov = 1'b1; end
        end else begin
          nq = i2b(b2i(q) + 1);
        end
      end
    end
  endtask

  // Reference model: plain decimal arithmetic on the count
  always @(posedge clk or negedge rst) begin : model
    logic [W-1:0] nq;
    logic ntc, nov;
    if (!rst) begin
      mq <= '0; mtc <= 1'b0; movf <= 1'b0;
    end else begin
      model_step(mq, movf, nq, ntc, nov);
      mq <= nq; mtc <= ntc; movf <= nov;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model on the falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_q", 32'(Qdata), 32'(mq));
      chk("m_tc", 32'(tc), 32'(mtc));
      chk("m_ovf", 32'(ovf), 32'(movf));
      chk("m_blink", 32'(blink), 32'(mblink(mq, match_val)));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load = 1'b1;
    load_val = v;
    tick(1);
    load = 1'b0;
  endtask

  initial begin
    #3;
    chk("rst_q", 32'(Qdata), 32'h0);
    chk("rst_tc", 32'(tc), 32'h0);
    chk("rst_ovf", 32'(ovf), 32'h0);
    tick(1);
    rst = 1'b1;
    chk_en = 1'b1;
    ena = 1'b1;
    tick(10);
    chk("cnt10", 32'(Qdata), 32'h0010);
    do_load(16'h0098);
    tick(1);
    chk("c99", 32'(Qdata), 32'h0099);
    tick(1);
    chk("c100", 32'(Qdata), 32'h0100);

    do_load(16'h9674);
    tick(1);
    chk("w_lim", 32'(Qdata), 32'h9675);
    chk("w_tc0", 32'(tc), 32'h0);
    tick(1);
    chk("w_zero", 32'(Qdata), 32'h0000);
    chk("w_tc1", 32'(tc), 32'h1);
    chk("w_ovf", 32'(ovf), 32'h1);
    tick(1);
    chk("w_next", 32'(Qdata), 32'h0001);
    chk("w_tcoff", 32'(tc), 32'h0);
    tick(3);
    chk("w_sticky", 32'(ovf), 32'h1);

    mode = 1'b1;
    do_load(16'h9674);
    chk("ld_tc", 32'(tc), 32'h0);
    chk("ld_ovf", 32'(ovf), 32'h0);
    tick(2);
    chk("s_hold", 32'(Qdata), 32'h9675);
    chk("s_tc", 32'(tc), 32'h1);
    tick(3);
    chk("s_hold2", 32'(Qdata), 32'h9675);
    chk("s_tc2", 32'(tc), 32'h1);
    chk("s_ovf", 32'(ovf), 32'h0);
    limit = 16'h9680;
    tick(1);
    chk("live_lim", 32'(Qdata), 32'h9676);
    chk("live_tc", 32'(tc), 32'h0);

    mode = 1'b0;
    limit = 16'h0100;
    do_load(16'h9998);
    tick(1);
    chk("a_9999", 32'(Qdata), 32'h9999);
    tick(1);
    chk("a_wrap", 32'(Qdata), 32'h0000);
    chk("a_ovf", 32'(ovf), 32'h1);
    do_load(16'h12C4);
    chk("ld_bad", 32'(Qdata), 32'h1204);
    limit = 16'h96A5;
    do_load(16'h9998);
    tick(2);
    chk("badlim", 32'(Qdata), 32'h0000);

    limit = 16'h9675;
    dir = 1'b1;
    do_load(16'h0001);
    tick(1);
`ifdef BCD_CHAIN_DOWN_EN
    chk("d_zero", 32'(Qdata), 32'h0000);
    tick(1);
    chk("d_wrap", 32'(Qdata), 32'h9675);
    chk("d_tc", 32'(tc), 32'h1);
    chk("d_ovf", 32'(ovf), 32'h1);
    do_load(16'h1000);
    tick(1);
    chk("d_borrow", 32'(Qdata), 32'h0999);
`else
    chk("dir_ign", 32'(Qdata), 32'h0002);
    tick(1);
    chk("dir_ign2", 32'(Qdata), 32'h0003);
`endif
    dir = 1'b0;

    ena = 1'b0;
    match_val = 16'h9675;
    do_load(16'h9605);
    chk("blink", 32'(blink), 32'hD);
    tick(2);
    chk("hold", 32'(Qdata), 32'h9605);
    chk("hold_tc", 32'(tc), 32'h0);

    ena = 1'b1;
    do_load(16'h9675);
    tick(2);
    chk("pre_q", 32'(Qdata), 32'h0001);
    chk("pre_ovf", 32'(ovf), 32'h1);
    rst = 1'b0;
    #1;
    chk("ar_q", 32'(Qdata), 32'h0);
    chk("ar_tc", 32'(tc), 32'h0);
    chk("ar_ovf", 32'(ovf), 32'h0);
    #1;
    rst = 1'b1;
    tick(1);
    chk("post_q", 32'(Qdata), 32'h0001);
    tick(1);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
